fft_frame_sequencer: RTL
========================

Name: fft_frame_sequencer

Overview:
- Sequences the 64-point FFT core (fft_controller) for the audio path. Accepts a stream of real 16-bit audio samples and loads 64 of them into the core, then pulses start and waits for done.
- Then streams the lower-half spectrum bins (0..31) to a downstream consumer over a valid/ready handshake.
- Sits between the sample capture front end and the pitch/harmonizer logic. Owns all fft_controller control ports.

Parameters:
- N_POINTS, 64, FFT length; the load counter wraps at N_POINTS-1.
- ADDR_W, 6, width of the FFT address bus (log2 N_POINTS).
- OUT_BINS, 32, number of bins streamed out per frame, starting at bin 0.
- WAIT_LIMIT, 4096, maximum cycles spent in WAIT before a timeout is declared.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- sample_valid  in  1  input sample present.
- sample_data  in  16  signed real audio sample.
- sample_ready  out  1  sequencer accepts a sample this cycle.
- fft_load  out  1  write strobe to the core (drives its load).
- fft_start  out  1  one-cycle transform start pulse.
- fft_addr  out  ADDR_W  drives the core's read_address for both loads and reads.
- fft_wdata  out  32  drives the core's data_in.
- fft_done  in  1  core done, level, held until the next start.
- fft_rdata  in  32  core data_out; valid 1 cycle after fft_addr is presented.
- bin_valid  out  1  bin_data/bin_index valid.
- bin_ready  in  1  consumer accepts the bin.
- bin_index  out  ADDR_W  index of the current bin.
- bin_data  out  32  bin value: {real[31:16], imag[15:0]}.
- frame_count  out  8  completed frames, wraps 255->0.
- timeout_err  out  1  sticky; set on a WAIT timeout.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=LOAD; load counter, bin counter and WAIT timer set to 0.
  - bin_valid=0, bin_index=0, bin_data=0, frame_count=0, timeout_err=0.
  - fft_start=0, fft_load=0, fft_addr=0, fft_wdata=0, sample_ready=0.
  - Reset mid-frame abandons the frame; the core is not notified.
- Decoded outputs: sample_ready, fft_load, fft_start and fft_addr are combinational decodes of the registered state and counters. fft_wdata is combinational from sample_data. With reset high, sample_ready=1 in the first LOAD cycle.
- LOAD:
  - sample_ready=1.
  - fft_load = sample_valid & sample_ready.
  - fft_addr = load counter.
  - fft_wdata = {sample_data, 16'h0000}, i.e. imaginary part zero, natural sample order.
  - On each accepted sample the counter increments.
  - When the accepted sample is at address N_POINTS-1: counter->0, go to START.
- START:
  - fft_start=1 for exactly one cycle; sample_ready=0; fft_load=0.
  - WAIT timer cleared; go to WAIT.
- WAIT:
  - All core strobes low; sample_ready=0. Samples arriving now are back-pressured, not dropped.
  - If fft_done==1: bin counter->0, go to RD_ADDR.
  - Else if timer==WAIT_LIMIT-1: timeout_err<=1, go to LOAD. The frame is discarded and frame_count is unchanged.
  - Else the timer increments.
  - If fft_done and the timeout coincide, done wins.
- RD_ADDR: fft_addr = bin counter; go to RD_DATA.
- RD_DATA:
  - bin_data<=fft_rdata, bin_index<=bin counter, bin_valid<=1.
  - fft_addr is held at the bin counter; go to HOLD.
- HOLD:
  - bin_valid, bin_data and bin_index are held stable while bin_ready==0.
  - On bin_valid & bin_ready: bin_valid<=0.
    - If bin counter==OUT_BINS-1: frame_count++ (wrapping), go to LOAD.
    - Else: bin counter++, go to RD_ADDR.
  - Throughput is one bin per 3 cycles with bin_ready held high.
- Latency from the 64th accepted sample: fft_start is high the next cycle. From the first fft_done cycle, bin 0 is valid 3 cycles later.
- fft_load and fft_start are never high together. fft_load is never high outside LOAD.
- timeout_err clears only on reset. Operation continues normally after a timeout.

Test Plan:
- Frame load:
  - Stimulus: reset low 2 cycles, then release; stream samples 0x0000..0x003F with sample_valid held high.
  - Required: fft_load is high 64 cycles with fft_addr 0..63 and fft_wdata={k,16'h0}. fft_start pulses exactly once, the cycle after addr 63. sample_ready is low afterward.
- Bin readout:
  - Stimulus: model the core returning fft_rdata = {addr, ~addr} (16b each) one cycle after the address; assert fft_done 10 cycles after start; hold bin_ready high.
  - Required: 32 bins with index 0..31 and matching data, first bin_valid 3 cycles after done. frame_count=1; LOAD is re-entered.
- Backpressure:
  - Stimulus: hold bin_ready low for 5 cycles on bin 7.
  - Required: bin_valid, bin_index=7 and bin_data stay stable; no extra fft_addr change; bin 8 follows normally.
- Timeout:
  - Stimulus: never assert fft_done, with WAIT_LIMIT=16.
  - Required: after 16 WAIT cycles timeout_err=1, state returns to LOAD, frame_count unchanged. The next frame completes normally and timeout_err stays 1.
- Reset mid-readout:
  - Stimulus: reset low during bin 12.
  - Required: next cycle bin_valid=0, frame_count=0, timeout_err=0, fft_addr=0. After release the load restarts at address 0.
- Wrap:
  - Stimulus: run 256 frames.
  - Required: frame_count wraps 255->0.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for the 64-point FFT core: loads real samples, starts the
// transform, waits for done, then streams bins 0..OUT_BINS-1 over valid/ready.
module fft_frame_sequencer #(
    parameter int N_POINTS   = 64,
    parameter int ADDR_W     = 6,
    parameter int OUT_BINS   = 32,
    parameter int WAIT_LIMIT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [15:0]       sample_data,
    output logic              sample_ready,
    output logic              fft_load,
    output logic              fft_start,
    output logic [ADDR_W-1:0] fft_addr,
    output logic [31:0]       fft_wdata,
    input  logic              fft_done,
    input  logic [31:0]       fft_rdata,
    output logic              bin_valid,
    input  logic              bin_ready,
    output logic [ADDR_W-1:0] bin_index,
    output logic [31:0]       bin_data,
    output logic [7:0]        frame_count,
    output logic              timeout_err
);

    localparam int TMR_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_POINTS - 1);
    localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(OUT_BINS - 1);
    localparam logic [TMR_W-1:0]  LAST_TICK = TMR_W'(WAIT_LIMIT - 1);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_load_cnt;
    logic [ADDR_W-1:0] r_bin_cnt;
    logic [TMR_W-1:0]  r_timer;
    logic              r_bin_valid;
    logic [ADDR_W-1:0] r_bin_index;
    logic [31:0]       r_bin_data;
    logic [7:0]        r_frame_count;
    logic              r_timeout_err;
    logic              w_bin_taken;

    assign bin_valid   = r_bin_valid;
    assign bin_index   = r_bin_index;
    assign bin_data    = r_bin_data;
    assign frame_count = r_frame_count;
    assign timeout_err = r_timeout_err;
    assign w_bin_taken = r_bin_valid & bin_ready;

    // Core strobes are qualified by reset so nothing reaches the core while held in reset.
    always_comb begin
        w_state_next = r_state;
        sample_ready = 1'b0;
        fft_load     = 1'b0;
        fft_start    = 1'b0;
        fft_addr     = '0;
        fft_wdata    = '0;
        if (reset) begin
            case (r_state)
                S_LOAD: begin
                    sample_ready = 1'b1;
                    fft_load     = sample_valid;
                    fft_addr     = r_load_cnt;
                    if (sample_valid) begin
                        fft_wdata = {sample_data, 16'h0000};
                        if (r_load_cnt == LAST_ADDR)
                            w_state_next = S_START;
                    end
                end
                S_START: begin
                    fft_start    = 1'b1;
                    w_state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (fft_done)
                        w_state_next = S_RD_ADDR;
                    else if (r_timer == LAST_TICK)
                        w_state_next = S_LOAD;
                end
                S_RD_ADDR: begin
                    fft_addr     = r_bin_cnt;
                    w_state_next = S_RD_DATA;
                end
                S_RD_DATA: begin
                    fft_addr     = r_bin_cnt;
                    w_state_next = S_HOLD;
                end
                S_HOLD: begin
                    fft_addr = r_bin_cnt;
                    if (w_bin_taken)
                        w_state_next = (r_bin_cnt == LAST_BIN) ? S_LOAD : S_RD_ADDR;
                end
                default: w_state_next = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_LOAD;
            r_load_cnt    <= '0;
            r_bin_cnt     <= '0;
            r_timer       <= '0;
            r_bin_valid   <= 1'b0;
            r_bin_index   <= '0;
            r_bin_data    <= '0;
            r_frame_count <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_LOAD: begin
                    if (fft_load)
                        r_load_cnt <= (r_load_cnt == LAST_ADDR) ? '0 : r_load_cnt + 1'b1;
                end
                S_START: r_timer <= '0;
                S_WAIT: begin
                    // done has priority over an expiring timer
                    if (fft_done)
                        r_bin_cnt <= '0;
                    else if (r_timer == LAST_TICK)
                        r_timeout_err <= 1'b1;
                    else
                        r_timer <= r_timer + 1'b1;
                end
                S_RD_DATA: begin
                    r_bin_data  <= fft_rdata;
                    r_bin_index <= r_bin_cnt;
                    r_bin_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (w_bin_taken) begin
                        r_bin_valid <= 1'b0;
                        if (r_bin_cnt == LAST_BIN)
                            r_frame_count <= r_frame_count + 8'd1;
                        else
                            r_bin_cnt <= r_bin_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
